// File: rtl/video_write_queue_if.sv
// Command bus from the CPU side into the video write queue.
interface video_write_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_cmd;
    logic [1:0]  in_param;
    logic [10:0] in_index;
    logic [15:0] in_val;

    modport master (
        output in_valid, in_cmd, in_param, in_index, in_val,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_cmd, in_param, in_index, in_val,
        output in_ready
    );
endinterface

// File: rtl/video_write_queue.sv
// Buffers CPU video-register writes and replays them onto the renderer write port.
// Optional VIDEO_WQ_VBLANK_ONLY_EN: drain only while the registered vblank flag is set.
module video_write_queue #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                resetn,
    video_write_queue_if.slave  cmd,
    input  logic                vblank,
    output logic                wen,
    output logic [1:0]          w_param,
    output logic [10:0]         w_index,
    output logic [15:0]         w_val,
    output logic [LW-1:0]       level,
    output logic                empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        CMD_WRITE     = 2'd0,
        CMD_SETPTR    = 2'd1,
        CMD_WRITE_INC = 2'd2,
        CMD_RSVD      = 2'd3
    } cmd_e;

    typedef struct packed {
        logic [1:0]  param;
        logic [10:0] index;
        logic [15:0] val;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [1:0]      ptr_param;
    logic [10:0]     ptr;

    logic            full;
    logic            accept;
    logic            push;
    logic            pop;
    logic            drain_ok;
    entry_t          push_entry;
    logic [1:0]      ptr_param_nxt;
    logic [10:0]     ptr_nxt;
    logic [LW-1:0]   level_nxt;
    cmd_e            cmd_dec;

    // Entries per target table; pointers wrap at this bound.
    function automatic logic [10:0] limit_of(input logic [1:0] p);
        case (p)
            2'd0:    limit_of = 11'd16;
            2'd1:    limit_of = 11'd256;
            default: limit_of = 11'd1200;
        endcase
    endfunction

`ifdef VIDEO_WQ_VBLANK_ONLY_EN
    logic vblank_q;

    always_ff @(posedge clk) begin
        if (!resetn) vblank_q <= 1'b0;
        else         vblank_q <= vblank;
    end

    assign drain_ok = vblank_q;
`else
    logic unused_vblank;

    assign unused_vblank = vblank;
    assign drain_ok      = 1'b1;
`endif

    // No bypass: a same-cycle pop does not open a slot for a push when full.
    assign full         = (level == LW'(DEPTH));
    assign cmd.in_ready = resetn && !full;
    assign accept       = cmd.in_valid && cmd.in_ready;
    assign cmd_dec      = cmd_e'(cmd.in_cmd);
    assign pop          = !empty && drain_ok;

    // Command decode: what to enqueue and how the write pointer moves.
    always_comb begin
        push          = 1'b0;
        push_entry    = '0;
        ptr_param_nxt = ptr_param;
        ptr_nxt       = ptr;
        if (accept) begin
            case (cmd_dec)
                CMD_WRITE: begin
                    push       = 1'b1;
                    push_entry = '{param: cmd.in_param, index: cmd.in_index, val: cmd.in_val};
                end
                CMD_SETPTR: begin
                    ptr_param_nxt = cmd.in_param;
                    ptr_nxt       = (cmd.in_index >= limit_of(cmd.in_param)) ? 11'd0 : cmd.in_index;
                end
                CMD_WRITE_INC: begin
                    push       = 1'b1;
                    push_entry = '{param: ptr_param, index: ptr, val: cmd.in_val};
                    ptr_nxt    = (ptr == limit_of(ptr_param) - 11'd1) ? 11'd0 : ptr + 11'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty     <= 1'b1;
            ptr_param <= '0;
            ptr       <= '0;
            wen       <= 1'b0;
            w_param   <= '0;
            w_index   <= '0;
            w_val     <= '0;
        end else begin
            ptr_param <= ptr_param_nxt;
            ptr       <= ptr_nxt;
            level     <= level_nxt;
            empty     <= (level_nxt == '0);
            wen       <= pop;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                w_param <= mem[rd_ptr].param;
                w_index <= mem[rd_ptr].index;
                w_val   <= mem[rd_ptr].val;
            end
        end
    end
endmodule
